// File: rtl/pen_jog_pkg.sv
// Shared types for the pen carriage jog controller:
// FSM states, jog request codes and a saturating counter step.
package pen_jog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LIFT  = 3'd1,
    ST_JOG   = 3'd2,
    ST_LOWER = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_POS  = 2'd1,
    REQ_NEG  = 2'd2
  } req_e;

  // One unit up or down, clamped to a signed w-bit range.
  function automatic logic signed [31:0] sat_step(
    input logic signed [31:0] a,
    input logic               neg,
    input int unsigned        w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (neg) return (a <= lo) ? lo : a - 32'sd1;
    return (a >= hi) ? hi : a + 32'sd1;
  endfunction

endpackage

// File: rtl/jog_step_gen.sv
// Per-axis step generator: period counter, step toggle,
// direction setup suppression and rising-edge strobe.
module jog_step_gen
  import pen_jog_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             setup_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             dir_req_i,
  output logic             step_o,
  output logic             dir_o,
  output logic             tgl_o,
  output logic             rise_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, dir_q, dir_d;

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    tgl_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      if (!setup_i) dir_d = dir_req_i;
    end else begin
      dir_d = dir_req_i;
      // A reversal spends this cycle on setup only.
      if (setup_i && (dir_req_i != dir_q)) begin
        cnt_d = '0;
      end else if (cnt_q >= period_i - 1'b1) begin
        tgl_o = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clr_i) cnt_d = '0;
  end

  assign rise_o = tgl_o & ~step_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_q ^ tgl_o;
      dir_q  <= dir_d;
    end
  end

endmodule

// File: rtl/pen_jog_ctrl.sv
// Multi-axis manual jog controller: lift pen, jog axes,
// lower pen by the exact lifted distance, report offsets.
module pen_jog_ctrl
  import pen_jog_pkg::*;
#(
  parameter int N_AXIS      = 3,
  parameter int Z_AXIS      = 2,
  parameter int CNT_W       = 24,
  parameter int LIFT_EDGES  = 3200,
  parameter int LIFT_PERIOD = 10000,
  parameter int JOG_SLOW    = 300000,
  parameter int JOG_FAST    = 100000,
  parameter int POS_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    jog_req,
  input  logic                    ok,
  input  logic                    abort,
  input  logic                    fast,
  input  logic [N_AXIS-1:0]       up,
  input  logic [N_AXIS-1:0]       down,
  output logic [N_AXIS-1:0]       step,
  output logic [N_AXIS-1:0]       dir,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              state,
  output logic [N_AXIS*POS_W-1:0] jog_pos
);

  localparam int SW = 4 + 2 * N_AXIS;

  logic [SW-1:0]     raw, s1_q, s2_q;
  logic              req_prev_q, ok_prev_q;
  logic [N_AXIS-1:0] up_s, down_s;
  logic              fast_s, abort_s, ok_s, req_s;
  logic              req_rise, ok_rise;

  assign raw    = {jog_req, ok, abort, fast, up, down};
  assign down_s = s2_q[N_AXIS-1:0];
  assign up_s   = s2_q[2*N_AXIS-1:N_AXIS];
  assign fast_s = s2_q[2*N_AXIS];
  assign abort_s = s2_q[2*N_AXIS+1];
  assign ok_s   = s2_q[2*N_AXIS+2];
  assign req_s  = s2_q[2*N_AXIS+3];
  assign req_rise = req_s & ~req_prev_q;
  assign ok_rise  = ok_s & ~ok_prev_q;

  state_e                  state_q, state_d;
  logic                    busy_q, done_q, clr;
  logic [CNT_W-1:0]        lift_q, lift_d;
  logic signed [POS_W-1:0] pos_q [N_AXIS];
  logic signed [POS_W-1:0] pos_d [N_AXIS];
  req_e                    rq [N_AXIS];
  logic [N_AXIS-1:0]       en, setup, drq, tgl, rise;
  logic [CNT_W-1:0]        per [N_AXIS];

  always_comb begin
    for (int i = 0; i < N_AXIS; i++) begin
      unique case ({up_s[i], down_s[i]})
        2'b10:   rq[i] = REQ_POS;
        2'b01:   rq[i] = REQ_NEG;
        default: rq[i] = REQ_NONE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_AXIS; i++) begin
      en[i]    = 1'b0;
      setup[i] = 1'b1;
      drq[i]   = 1'b0;
      per[i]   = CNT_W'(JOG_SLOW);
      if (state_q == ST_JOG) begin
        en[i]  = (rq[i] != REQ_NONE);
        drq[i] = (rq[i] == REQ_POS);
        per[i] = fast_s ? CNT_W'(JOG_FAST)
                        : CNT_W'(JOG_SLOW);
      end else if (i == Z_AXIS) begin
        per[i] = CNT_W'(LIFT_PERIOD);
        if (state_q == ST_LIFT) begin
          en[i]    = 1'b1;
          setup[i] = 1'b0;
          drq[i]   = 1'b1;
        end else if (state_q == ST_LOWER) begin
          en[i]    = (lift_q != '0);
          setup[i] = 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_AXIS; g++) begin : g_ax
    jog_step_gen #(.CNT_W(CNT_W)) u_gen (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr),
      .en_i      (en[g]),
      .setup_i   (setup[g]),
      .period_i  (per[g]),
      .dir_req_i (drq[g]),
      .step_o    (step[g]),
      .dir_o     (dir[g]),
      .tgl_o     (tgl[g]),
      .rise_o    (rise[g])
    );
  end

  always_comb begin
    state_d = state_q;
    lift_d  = lift_q;
    pos_d   = pos_q;
    unique case (state_q)
      ST_IDLE: if (req_rise) begin
        state_d = ST_LIFT;
        lift_d  = '0;
        for (int i = 0; i < N_AXIS; i++) pos_d[i] = '0;
      end
      ST_LIFT: begin
        if (tgl[Z_AXIS]) lift_d = lift_q + 1'b1;
        if (abort_s) state_d = ST_LOWER;
        else if (lift_q == CNT_W'(LIFT_EDGES))
          state_d = ST_JOG;
      end
      ST_JOG: begin
        for (int i = 0; i < N_AXIS; i++) begin
          if (rise[i]) pos_d[i] = POS_W'(sat_step(
            {{(32-POS_W){pos_q[i][POS_W-1]}}, pos_q[i]},
            rq[i] == REQ_NEG, POS_W));
        end
        if (ok_rise || abort_s) state_d = ST_LOWER;
      end
      ST_LOWER: begin
        if (tgl[Z_AXIS]) lift_d = lift_q - 1'b1;
        if (lift_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr = (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      req_prev_q <= 1'b0;
      ok_prev_q  <= 1'b0;
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lift_q     <= '0;
      for (int i = 0; i < N_AXIS; i++) pos_q[i] <= '0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      req_prev_q <= req_s;
      ok_prev_q  <= ok_s;
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      lift_q     <= lift_d;
      pos_q      <= pos_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

  always_comb begin
    jog_pos = '0;
    for (int i = 0; i < N_AXIS; i++)
      jog_pos[i*POS_W +: POS_W] = pos_q[i];
  end

endmodule

// File: tb/tb_pen_jog_ctrl.sv
// Self-checking bench for pen_jog_ctrl: vector table,
// corner sequences and a segment-level random model.
module tb_pen_jog_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jog_req = 1'b0;
  logic        ok = 1'b0;
  logic        abort = 1'b0;
  logic        fast = 1'b0;
  logic [2:0]  up = '0;
  logic [2:0]  down = '0;
  logic [2:0]  step, dir;
  logic        busy, done;
  logic [2:0]  state;
  logic [23:0] jog_pos;

  pen_jog_ctrl #(
    .N_AXIS(3), .Z_AXIS(2), .CNT_W(24),
    .LIFT_EDGES(4), .LIFT_PERIOD(10),
    .JOG_SLOW(50), .JOG_FAST(20), .POS_W(8)
  ) dut (
    .clk(clk), .rst(rst), .jog_req(jog_req),
    .ok(ok), .abort(abort), .fast(fast),
    .up(up), .down(down), .step(step), .dir(dir),
    .busy(busy), .done(done), .state(state),
    .jog_pos(jog_pos)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Edge monitor: counts toggles by state.
  logic [2:0] ps = '0;
  int tgl_n [3] = '{0, 0, 0};
  int lift_t = 0, lower_t = 0, done_n = 0;
  int lift_db = 0, lower_db = 0, nz_bad = 0;

  always @(negedge clk) begin
    ps <= step;
    if (!rst) begin
      if (done) done_n <= done_n + 1;
      for (int a = 0; a < 3; a++) begin
        if (step[a] !== ps[a]) begin
          tgl_n[a] <= tgl_n[a] + 1;
          if (a != 2 && state inside {3'd0, 3'd1, 3'd4})
            nz_bad <= nz_bad + 1;
        end
      end
      if (step[2] !== ps[2] && state == 3'd1) begin
        lift_t <= lift_t + 1;
        if (dir[2] !== 1'b1) lift_db <= lift_db + 1;
      end
      if (step[2] !== ps[2] && state == 3'd3) begin
        lower_t <= lower_t + 1;
        if (dir[2] !== 1'b0) lower_db <= lower_db + 1;
      end
    end
  end

  // Segment-level reference model.
  bit dir_m [3];
  bit step_m [3];
  int pos_m [3];

  function automatic logic [23:0] pk();
    logic [23:0] r;
    for (int a = 0; a < 3; a++) r[a*8 +: 8] = 8'(pos_m[a]);
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int lim,
                            input string nm);
    int n = 0;
    while (state !== s && n < lim) begin
      cyc(1);
      n++;
    end
    chk(nm, state, s);
  endtask

  task automatic seg(input logic [2:0] u,
                     input logic [2:0] d,
                     input logic f, input int len);
    int r, p, c, t, rs;
    up = u;
    down = d;
    fast = f;
    cyc(len);
    up = '0;
    down = '0;
    cyc(4);
    for (int a = 0; a < 3; a++) begin
      r = (u[a] && !d[a]) ? 1 : (d[a] && !u[a]) ? -1 : 0;
      if (r != 0) begin
        p = f ? 20 : 50;
        c = len;
        if (dir_m[a] != (r > 0)) begin
          c--;
          dir_m[a] = (r > 0);
        end
        t = c / p;
        rs = step_m[a] ? t / 2 : (t + 1) / 2;
        if (t % 2 == 1) step_m[a] = !step_m[a];
        pos_m[a] += r * rs;
        if (pos_m[a] > 127) pos_m[a] = 127;
        if (pos_m[a] < -128) pos_m[a] = -128;
      end
    end
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_step"}, step,
        {step_m[2], step_m[1], step_m[0]});
    chk({nm, "_dir"}, dir,
        {dir_m[2], dir_m[1], dir_m[0]});
    chk({nm, "_pos"}, jog_pos, pk());
  endtask

  task automatic start_session();
    int b = lift_t;
    jog_req = 1'b1;
    cyc(3);
    jog_req = 1'b0;
    wait_state(3'd2, 200, "jog_entry");
    chk("lift_edges", lift_t - b, 4);
    dir_m[2] = 1'b1;
    for (int a = 0; a < 3; a++) pos_m[a] = 0;
  endtask

  task automatic end_session();
    int b1 = lower_t;
    int b2 = done_n;
    ok = 1'b1;
    cyc(3);
    ok = 1'b0;
    wait_state(3'd0, 200, "idle_return");
    cyc(1);
    chk("lower_edges", lower_t - b1, 4);
    chk("done_pulses", done_n - b2, 1);
    chk("busy_idle", busy, 1'b0);
    chk("pos_hold", jog_pos, pk());
    dir_m[2] = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  u;
    logic [2:0]  d;
    logic        f;
    int          len;
    logic [2:0]  e_step;
    logic [2:0]  e_dir;
    logic [23:0] e_pos;
    int          e_t1;
  } vec_t;

  vec_t tbl [5];
  int tq [$];

  initial begin
    int k, b, tb1;
    logic pv;
    logic [2:0] u, d;
    tbl[0] = '{3'b001, 3'b000, 1'b1, 200,
               3'b001, 3'b101, 24'h000005, 0};
    tbl[1] = '{3'b000, 3'b001, 1'b1, 100,
               3'b001, 3'b100, 24'h000003, 0};
    tbl[2] = '{3'b010, 3'b010, 1'b0, 500,
               3'b001, 3'b100, 24'h000003, 0};
    tbl[3] = '{3'b010, 3'b000, 1'b0, 151,
               3'b011, 3'b110, 24'h000203, 3};
    tbl[4] = '{3'b000, 3'b100, 1'b1, 61,
               3'b111, 3'b010, 24'hFE0203, 3};

    #2 rst = 1'b1;
    cyc(3);
    chk("rst_step", step, 3'b000);
    chk("rst_dir", dir, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", state, 3'd0);
    chk("rst_pos", jog_pos, 24'h0);
    rst = 1'b0;
    cyc(2);

    // Basic session with exact lift timing.
    jog_req = 1'b1;
    cyc(2);
    chk("busy_pre", busy, 1'b0);
    cyc(1);
    chk("busy_lat3", busy, 1'b1);
    chk("lift_state", state, 3'd1);
    jog_req = 1'b0;
    k = 3;
    pv = step[2];
    repeat (41) begin
      cyc(1);
      k++;
      if (step[2] !== pv) begin
        tq.push_back(k);
        pv = step[2];
      end
    end
    chk("lift_n", tq.size(), 4);
    for (int i = 0; i < tq.size() && i < 4; i++)
      chk($sformatf("lift_t%0d", i), tq[i], 13 + 10 * i);
    chk("jog_state", state, 3'd2);
    chk("lift_dir", dir[2], 1'b1);
    dir_m[2] = 1'b1;

    b = lift_t;
    jog_req = 1'b1;
    cyc(3);
    jog_req = 1'b0;
    cyc(5);
    chk("busy_req_state", state, 3'd2);
    chk("busy_req_lift", lift_t - b, 0);

    tb1 = tgl_n[1];
    for (int i = 0; i < 5; i++) begin
      seg(tbl[i].u, tbl[i].d, tbl[i].f, tbl[i].len);
      chk($sformatf("tbl%0d_step", i), step, tbl[i].e_step);
      chk($sformatf("tbl%0d_dir", i), dir, tbl[i].e_dir);
      chk($sformatf("tbl%0d_pos", i), jog_pos, tbl[i].e_pos);
      chk($sformatf("tbl%0d_t1", i), tgl_n[1] - tb1,
          tbl[i].e_t1);
    end
    end_session();
    chk("s1_pos_final", jog_pos, 24'hFE0203);

    // Abort after the second lift edge.
    b = lift_t;
    tb1 = lower_t;
    k = done_n;
    jog_req = 1'b1;
    cyc(3);
    jog_req = 1'b0;
    for (int n = 0; n < 100 && lift_t - b < 2; n++) cyc(1);
    abort = 1'b1;
    wait_state(3'd0, 200, "abort_idle");
    abort = 1'b0;
    cyc(1);
    chk("abort_lift", lift_t - b, 2);
    chk("abort_lower", lower_t - tb1, 2);
    chk("abort_done", done_n - k, 1);
    chk("abort_pos_clr", jog_pos, 24'h0);
    for (int a = 0; a < 3; a++) pos_m[a] = 0;
    dir_m[2] = 1'b0;

    // Saturation on axis 0.
    start_session();
    seg(3'b001, 3'b000, 1'b1, 5200);
    chk("sat_pos0", jog_pos[7:0], 8'd127);
    chk_model("sat");
    end_session();

    // Random segments against the model.
    for (int s = 0; s < 3; s++) begin
      start_session();
      for (int j = 0; j < 6; j++) begin
        for (int a = 0; a < 3; a++) begin
          k = $urandom_range(0, 3);
          u[a] = (k == 1 || k == 3);
          d[a] = (k == 2 || k == 3);
        end
        seg(u, d, 1'($urandom_range(0, 1)),
            $urandom_range(20, 300));
        chk_model($sformatf("rnd%0d_%0d", s, j));
      end
      end_session();
    end

    // Async reset in JOG with step[0] high.
    start_session();
    up = 3'b001;
    fast = 1'b1;
    for (int n = 0; n < 200 && step[0] !== 1'b1; n++)
      cyc(1);
    chk("pre_rst_step0", step[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_step", step, 3'b000);
    chk("arst_dir", dir, 3'b000);
    chk("arst_busy", busy, 1'b0);
    chk("arst_pos", jog_pos, 24'h0);
    chk("arst_state", state, 3'd0);
    cyc(1);
    rst = 1'b0;
    up = '0;
    fast = 1'b0;
    cyc(3);
    chk("post_rst_state", state, 3'd0);

    chk("nz_idle_tgl", nz_bad, 0);
    chk("lift_dir_bad", lift_db, 0);
    chk("lower_dir_bad", lower_db, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pen_jog_ctrl.md
Name: pen_jog_ctrl

Overview:
Multi-axis manual jog controller for the pen carriage; the parametrised successor to the single-Z jog block.
- On a jog request it lifts the pen axis a fixed distance, then hands per-axis up/down buttons control at a selectable slow/fast rate.
- On OK (or abort) it lowers the pen by exactly the distance lifted and reports the net jog offset per axis.
- Sits between the front-panel button synchronisers and the stepper driver mux, ahead of the drawing sequencer.

Parameters:
N_AXIS, 3, number of stepper axes driven
Z_AXIS, 2, index of the pen-lift axis (0..N_AXIS-1)
CNT_W, 24, width of period counters
LIFT_EDGES, 3200, step-output toggles for lift and for lower
LIFT_PERIOD, 10000, clocks between toggles during lift/lower
JOG_SLOW, 300000, clocks between toggles in JOG with fast=0
JOG_FAST, 100000, clocks between toggles in JOG with fast=1
POS_W, 16, width of each signed jog-offset counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
jog_req  in  1  async button; rising edge starts a session
ok  in  1  async button; rising edge ends JOG
abort  in  1  async level; forces an early return
fast  in  1  async level; selects JOG_FAST period
up  in  N_AXIS  async per-axis jog-positive buttons
down  in  N_AXIS  async per-axis jog-negative buttons
step  out  N_AXIS  step outputs (toggle per edge)
dir  out  N_AXIS  direction outputs (1 = positive/lift)
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse on session completion
state  out  3  current FSM state encoding
jog_pos  out  N_AXIS*POS_W  signed net rising step edges per axis from the last session, axis 0 in LSBs

Behaviour:
- Reset (async, rst=1): step=0, dir=0, busy=0, done=0, state=IDLE, jog_pos=0, all counters and synchronisers 0.
- Input synchronisation: every async input passes through a 2-flop synchroniser. Edge detection on jog_req and ok uses the synchronised value versus its previous copy. Request-to-action latency is 3 clocks.
- Period tick: counter runs 0..P-1; tick when count==P-1, then the counter returns to 0. On each state entry the counter clears.
- States:
  - IDLE (0): wait for a jog_req edge. On the edge: clear jog_pos and lift_cnt, go to LIFT.
  - LIFT (1): dir[Z]=1. Each tick toggles step[Z] and increments lift_cnt. At lift_cnt==LIFT_EDGES go to JOG. abort=1 goes to LOWER.
  - JOG (2): each axis is independent, with period JOG_FAST if fast=1, else JOG_SLOW.
    - Request is +1 if up only, -1 if down only, 0 if both or neither.
    - Request 0: no toggles, and that axis's counter holds at 0.
    - When the request direction differs from the current dir: update dir that cycle, suppress the toggle, clear the counter (direction setup of at least one period).
    - Each step rising edge adds the request to jog_pos[axis], saturating at signed POS_W limits.
    - An ok edge or abort=1 goes to LOWER. If ok and a tick coincide, the tick's toggle still occurs.
  - LOWER (3): dir[Z]=0. Each tick toggles step[Z] and decrements lift_cnt. At lift_cnt==0 go to DONE. A partial lift is therefore undone exactly. If lift_cnt==0 on entry, go to DONE next clock. abort is ignored here.
  - DONE (4): done=1 for one clock, then IDLE. jog_pos holds until the next session start.
- Step level: step outputs keep their level between sessions. The edge count, not the phase, is the contract.
- Non-Z axes never toggle outside JOG. jog_req edges are ignored while busy.
- Reset mid-session: outputs go to reset values immediately, no lowering move. The integrator owns recovery.

Decomposition:
- Package pen_jog_pkg holds:
  - the state typedef/encodings (IDLE=0, LIFT=1, JOG=2, LOWER=3, DONE=4);
  - the jog-request encoding (NONE/POS/NEG);
  - the saturating-add helper function.
- Sub-module jog_step_gen is instantiated N_AXIS times. It contains the period counter, the toggle flop, dir setup suppression and the rising-edge strobe. Its inputs are enable, period and requested dir.
- The top level owns the synchronisers, the FSM, lift_cnt and the jog_pos accumulators.

Test Plan:
All scenarios use N_AXIS=3, Z_AXIS=2, LIFT_EDGES=4, LIFT_PERIOD=10, JOG_SLOW=50, JOG_FAST=20, POS_W=8.
1. Basic session: jog_req pulse → busy after 3 clocks, 4 step[2] toggles 10 clocks apart with dir[2]=1. Then JOG. ok edge → 4 toggles with dir[2]=0, done pulses once, state returns to 0.
2. Jog counting: in JOG hold up[0] with fast=1 for 200 clocks → step[0] toggles every 20 clocks. Release, then hold down[0] → first toggle suppressed by dir change. jog_pos[0] equals +rising edges then decrements correctly.
3. Both buttons: up[1]=down[1]=1 for 500 clocks → no step[1] activity, jog_pos[1]=0.
4. Abort mid-lift: abort asserted after the 2nd lift toggle → LOWER produces exactly 2 toggles with dir[2]=0, then done.
5. Saturation: force more than 127 positive rising edges on axis 0 → jog_pos[0] holds at +127.
6. Async reset: assert rst during JOG with step[0]=1 → step, dir, busy, jog_pos and state are 0 in the same cycle. A jog_req edge while busy produces no restart.
